// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder playout path: state encoding,
// default rates and the status record kept by the playout controller.
package decoder_pkg;

    // Playout FSM encoding; the numeric values are visible on the STATE port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2
    } play_state_e;

    // Defaults: 100 MHz ACLK, 16 kHz sample rate, 120 ms frames.
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TICK_DIV       = 6250;
    localparam int DEF_PREFILL_TICKS  = 4;
    localparam int DEF_FRAME_LEN      = 1920;
    localparam int DEF_UNDERRUN_LIMIT = 8;

    // Software-visible status, cleared as a unit by CLR_STATUS.
    typedef struct packed {
        logic [15:0] underrun_cnt;
        logic [15:0] frame_cnt;
        logic        frame_err;
        logic        overrun;
    } play_status_t;

    // Saturating increment for the underrun counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: counts 0..TICK_DIV-1 and pulses tick for one
// cycle on the terminal count. A synchronous clear holds it at zero so the
// first period after a restart is always a full TICK_DIV cycles long.
module sample_tick_gen
    import decoder_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic ACLK,
    input  logic ARESET_N,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: hold at zero while cleared, wrap on the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST_CNT);

endmodule

// File: rtl/decoder_playout_ctrl.sv
// Playout controller: paces decoded samples out of the FWFT decoder FIFO at
// one sample per tick onto an AXI-Stream master. Handles prefill, silence
// insertion on underrun, back-pressure (lost ticks flag OVERRUN) and checks
// frame lengths against the FIFO LAST markers.
module decoder_playout_ctrl
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TICK_DIV       = DEF_TICK_DIV,       // >= 2
    parameter int PREFILL_TICKS  = DEF_PREFILL_TICKS,  // >= 1
    parameter int FRAME_LEN      = DEF_FRAME_LEN,
    parameter int UNDERRUN_LIMIT = DEF_UNDERRUN_LIMIT  // >= 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET_N,
    input  logic                  ENABLE,
    input  logic                  CLR_STATUS,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_LAST,
    output logic                  FIFO_RD_EN,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic                  M_TLAST,
    output logic [1:0]            STATE,
    output logic [15:0]           UNDERRUN_CNT,
    output logic [15:0]           FRAME_CNT,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN
);

    // Prefill counter only needs to reach PREFILL_TICKS-1.
    localparam int PW = (PREFILL_TICKS > 1) ? $clog2(PREFILL_TICKS) : 1;
    // Consecutive-underrun and frame-sample counters must hold their limit.
    localparam int UW = $clog2(UNDERRUN_LIMIT + 1);
    localparam int SW = $clog2(FRAME_LEN + 1);

    play_state_e state_q, state_d;

    logic [PW-1:0]         prefill_cnt_q, prefill_cnt_d;
    logic [UW-1:0]         consec_q, consec_d;
    logic [SW-1:0]         smp_q, smp_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    play_status_t          status_q, status_d;

    logic          tick, tick_clr;
    logic          slot_free, play_tick;
    logic          pop, fill_silence, overrun_ev, underrun_hit;
    logic          prefill_done;
    logic [UW-1:0] consec_inc;
    logic [SW-1:0] smp_inc;

    // Sample-rate divider; held cleared in IDLE so it restarts on exit.
    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .ACLK     (ACLK),
        .ARESET_N (ARESET_N),
        .clr      (tick_clr),
        .tick     (tick)
    );

    assign slot_free    = !m_tvalid_q || M_TREADY;
    assign consec_inc   = consec_q + UW'(1);
    assign smp_inc      = smp_q + SW'(1);
    assign prefill_done = (prefill_cnt_q == PW'(PREFILL_TICKS - 1));

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: dropping ENABLE always returns to IDLE at once; a run
    // of UNDERRUN_LIMIT silent ticks abandons playback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE && !FIFO_EMPTY) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (!ENABLE)                   state_d = ST_IDLE;
                else if (tick && prefill_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!ENABLE || underrun_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: per-tick decision between pop, silence and lost tick.
    always_comb begin
        tick_clr     = (state_q == ST_IDLE);
        play_tick    = (state_q == ST_PLAY) && tick;
        pop          = play_tick && slot_free && !FIFO_EMPTY;
        fill_silence = play_tick && slot_free && FIFO_EMPTY;
        overrun_ev   = play_tick && !slot_free;
        underrun_hit = fill_silence && (consec_inc == UW'(UNDERRUN_LIMIT));
    end

    // Prefill tick count and consecutive-underrun run length.
    always_comb begin
        prefill_cnt_d = prefill_cnt_q;
        consec_d      = consec_q;
        if (state_q != ST_PREFILL)  prefill_cnt_d = '0;
        else if (tick)              prefill_cnt_d = prefill_cnt_q + PW'(1);
        if (state_q != ST_PLAY)     consec_d = '0;
        else if (pop)               consec_d = '0;
        else if (fill_silence)      consec_d = consec_inc;
    end

    // Output beat: load on pop or silence; valid only drops on handshake.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (pop) begin
            m_tdata_d  = FIFO_DATA;
            m_tlast_d  = FIFO_LAST;
            m_tvalid_d = 1'b1;
        end else if (fill_silence) begin
            m_tdata_d  = '0;
            m_tlast_d  = 1'b0;
            m_tvalid_d = 1'b1;
        end else if (M_TREADY) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Frame-length check on popped words and status updates; a clear
    // overrides any same-cycle increment but leaves the sample count alone.
    always_comb begin
        smp_d    = smp_q;
        status_d = status_q;
        if (pop) begin
            if (FIFO_LAST) begin
                status_d.frame_cnt = status_q.frame_cnt + 16'd1;
                if (smp_inc != SW'(FRAME_LEN)) status_d.frame_err = 1'b1;
                smp_d = '0;
            end else if (smp_inc == SW'(FRAME_LEN)) begin
                // Missing LAST: flag and resync on the expected boundary.
                status_d.frame_err = 1'b1;
                smp_d = '0;
            end else begin
                smp_d = smp_inc;
            end
        end
        if (fill_silence) status_d.underrun_cnt = sat_inc16(status_q.underrun_cnt);
        if (overrun_ev)   status_d.overrun = 1'b1;
        if (CLR_STATUS)   status_d = '0;
    end

    // Datapath and status registers.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            prefill_cnt_q <= '0;
            consec_q      <= '0;
            smp_q         <= '0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            status_q      <= '0;
        end else begin
            prefill_cnt_q <= prefill_cnt_d;
            consec_q      <= consec_d;
            smp_q         <= smp_d;
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            status_q      <= status_d;
        end
    end

    assign FIFO_RD_EN   = pop;
    assign M_TDATA      = m_tdata_q;
    assign M_TVALID     = m_tvalid_q;
    assign M_TLAST      = m_tlast_q;
    assign STATE        = state_q;
    assign UNDERRUN_CNT = status_q.underrun_cnt;
    assign FRAME_CNT    = status_q.frame_cnt;
    assign FRAME_ERR    = status_q.frame_err;
    assign OVERRUN      = status_q.overrun;

endmodule

// File: tb/tb_decoder_playout_ctrl.sv
// Directed bench for decoder_playout_ctrl with a small FWFT FIFO model.
// Cycle numbers are counted from the IDLE-exit edge (cycle 0 = first cycle
// in PREFILL); with TICK_DIV=4, PREFILL_TICKS=2 ticks fall on 3,7,11,...
module tb_decoder_playout_ctrl;

    logic        ACLK, ARESET_N, ENABLE, CLR_STATUS;
    logic        FIFO_EMPTY, FIFO_LAST, FIFO_RD_EN;
    logic [15:0] FIFO_DATA, M_TDATA, UNDERRUN_CNT, FRAME_CNT;
    logic        M_TVALID, M_TREADY, M_TLAST, FRAME_ERR, OVERRUN;
    logic [1:0]  STATE;

    decoder_playout_ctrl #(
        .DATA_WIDTH(16), .TICK_DIV(4), .PREFILL_TICKS(2),
        .FRAME_LEN(4), .UNDERRUN_LIMIT(8)
    ) dut (
        .ACLK(ACLK), .ARESET_N(ARESET_N), .ENABLE(ENABLE), .CLR_STATUS(CLR_STATUS),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_LAST(FIFO_LAST),
        .FIFO_RD_EN(FIFO_RD_EN), .M_TDATA(M_TDATA), .M_TVALID(M_TVALID),
        .M_TREADY(M_TREADY), .M_TLAST(M_TLAST), .STATE(STATE),
        .UNDERRUN_CNT(UNDERRUN_CNT), .FRAME_CNT(FRAME_CNT),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          pops  = 0;
    logic [15:0] fd[$];
    logic        fl[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        FIFO_EMPTY = (fd.size() == 0);
        FIFO_DATA  = FIFO_EMPTY ? 16'h0 : fd[0];
        FIFO_LAST  = FIFO_EMPTY ? 1'b0 : fl[0];
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        fd.push_back(d);
        fl.push_back(l);
        refresh();
    endtask

    // One clock from negedge to negedge; the FIFO pops on the edge where
    // RD_EN was high.
    task automatic step();
        logic        rd;
        logic [15:0] td;
        logic        tl;
        rd = FIFO_RD_EN;
        @(posedge ACLK);
        #1;
        if (rd && fd.size() > 0) begin
            td = fd.pop_front();
            tl = fl.pop_front();
            pops++;
        end
        refresh();
        @(negedge ACLK);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic start();
        ENABLE = 1'b1;
        cyc    = -1;
    endtask

    task automatic do_reset();
        ARESET_N   = 1'b0;
        ENABLE     = 1'b0;
        CLR_STATUS = 1'b0;
        M_TREADY   = 1'b1;
        fd.delete();
        fl.delete();
        refresh();
        step();
        step();
        ARESET_N = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_state"},  {30'd0, STATE}, 32'd0);
        check({pfx, "_tvalid"}, {31'd0, M_TVALID}, 32'd0);
        check({pfx, "_tdata"},  {16'd0, M_TDATA}, 32'd0);
        check({pfx, "_tlast"},  {31'd0, M_TLAST}, 32'd0);
        check({pfx, "_rd_en"},  {31'd0, FIFO_RD_EN}, 32'd0);
        check({pfx, "_undr"},   {16'd0, UNDERRUN_CNT}, 32'd0);
        check({pfx, "_fcnt"},   {16'd0, FRAME_CNT}, 32'd0);
        check({pfx, "_ferr"},   {31'd0, FRAME_ERR}, 32'd0);
        check({pfx, "_ovr"},    {31'd0, OVERRUN}, 32'd0);
    endtask

    initial begin
        int base;
        int vcnt;
        ARESET_N = 1'b0; ENABLE = 1'b0; CLR_STATUS = 1'b0; M_TREADY = 1'b1;
        refresh();
        @(negedge ACLK);
        step();
        check_all_zero("rst");
        ARESET_N = 1'b1;
        step();

        // Prefill, paced playout of 1..5 (LAST on 4th), then silence to abandon.
        push(16'h0001, 1'b0); push(16'h0002, 1'b0);
        push(16'h0003, 1'b0); push(16'h0004, 1'b1); push(16'h0005, 1'b0);
        base = pops;
        start();
        run_to(0);  check("t1_prefill", {30'd0, STATE}, 32'd1);
        run_to(7);  check("t1_still_prefill", {30'd0, STATE}, 32'd1);
        run_to(8);  check("t1_play", {30'd0, STATE}, 32'd2);
        run_to(10); check("t1_no_early_pop", {31'd0, FIFO_RD_EN}, 32'd0);
                    check("t1_pops_before", pops - base, 32'd0);
        run_to(11); check("t1_first_pop", {31'd0, FIFO_RD_EN}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            run_to(12 + 4 * k);
            check("t1_tdata",  {16'd0, M_TDATA}, k + 1);
            check("t1_tvalid", {31'd0, M_TVALID}, 32'd1);
            check("t1_tlast",  {31'd0, M_TLAST}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 0) begin
                run_to(13);
                check("t1_tvalid_drop", {31'd0, M_TVALID}, 32'd0);
            end
        end
        check("t1_fcnt", {16'd0, FRAME_CNT}, 32'd1);
        check("t1_ferr", {31'd0, FRAME_ERR}, 32'd0);
        run_to(32); check("t1_sil_data",  {16'd0, M_TDATA}, 32'd0);
                    check("t1_sil_valid", {31'd0, M_TVALID}, 32'd1);
                    check("t1_undr1", {16'd0, UNDERRUN_CNT}, 32'd1);
        run_to(59); check("t1_play_59", {30'd0, STATE}, 32'd2);
        run_to(60); check("t1_abandon", {30'd0, STATE}, 32'd0);
                    check("t1_undr8", {16'd0, UNDERRUN_CNT}, 32'd8);
                    check("t1_last_sil", {31'd0, M_TVALID}, 32'd1);
        vcnt = 0;
        run_to(61);
        for (int i = 0; i < 20; i++) begin
            if (M_TVALID) vcnt++;
            step();
        end
        check("t1_no_valid_after", vcnt, 32'd0);
        check("t1_pops_total", pops - base, 32'd5);

        // Short frame (LAST on 3rd word), status clear, clear beating increment.
        do_reset();
        push(16'h00B1, 1'b0); push(16'h00B2, 1'b0); push(16'h00B3, 1'b1);
        start();
        run_to(20); check("t2_fcnt", {16'd0, FRAME_CNT}, 32'd1);
                    check("t2_ferr", {31'd0, FRAME_ERR}, 32'd1);
        CLR_STATUS = 1'b1;
        run_to(21); CLR_STATUS = 1'b0;
                    check("t2_clr_fcnt", {16'd0, FRAME_CNT}, 32'd0);
                    check("t2_clr_ferr", {31'd0, FRAME_ERR}, 32'd0);
                    check("t2_clr_undr", {16'd0, UNDERRUN_CNT}, 32'd0);
                    check("t2_clr_ovr",  {31'd0, OVERRUN}, 32'd0);
                    check("t2_clr_state", {30'd0, STATE}, 32'd2);
        run_to(23); CLR_STATUS = 1'b1;
        run_to(24); CLR_STATUS = 1'b0;
                    check("t2_clr_wins", {16'd0, UNDERRUN_CNT}, 32'd0);
                    check("t2_sil_valid", {31'd0, M_TVALID}, 32'd1);
        run_to(28); check("t2_undr_after", {16'd0, UNDERRUN_CNT}, 32'd1);

        // Back-pressure across two ticks: beat held, overrun, one pop.
        do_reset();
        push(16'h00A1, 1'b0); push(16'h00A2, 1'b0); push(16'h00A3, 1'b0);
        base = pops;
        start();
        run_to(11); M_TREADY = 1'b0;
        run_to(20); check("t3_hold_data", {16'd0, M_TDATA}, 32'h00A1);
                    check("t3_hold_valid", {31'd0, M_TVALID}, 32'd1);
                    check("t3_overrun", {31'd0, OVERRUN}, 32'd1);
                    check("t3_one_pop", pops - base, 32'd1);
        M_TREADY = 1'b1;
        run_to(21); check("t3_handshake", {31'd0, M_TVALID}, 32'd0);
        run_to(24); check("t3_next_data", {16'd0, M_TDATA}, 32'h00A2);
                    check("t3_two_pops", pops - base, 32'd2);

        // ENABLE drop with a pending beat under back-pressure.
        do_reset();
        push(16'h00C1, 1'b0); push(16'h00C2, 1'b0); push(16'h00C3, 1'b0);
        base = pops;
        start();
        run_to(11); M_TREADY = 1'b0;
        run_to(13); ENABLE = 1'b0;
        run_to(14); check("t4_idle", {30'd0, STATE}, 32'd0);
                    check("t4_valid_kept", {31'd0, M_TVALID}, 32'd1);
                    check("t4_data_kept", {16'd0, M_TDATA}, 32'h00C1);
        run_to(17); check("t4_valid_17", {31'd0, M_TVALID}, 32'd1);
        M_TREADY = 1'b1;
        run_to(18); check("t4_valid_drop", {31'd0, M_TVALID}, 32'd0);
                    check("t4_one_pop", pops - base, 32'd1);

        // Asynchronous reset in the middle of playback.
        start();
        run_to(12); check("t5_play_data", {16'd0, M_TDATA}, 32'h00C2);
                    check("t5_play_state", {30'd0, STATE}, 32'd2);
        ARESET_N = 1'b0;
        #1;
        check_all_zero("t5_async");
        step(); step(); step();
        check("t5_rd_held", {31'd0, FIFO_RD_EN}, 32'd0);
        check("t5_state_held", {30'd0, STATE}, 32'd0);
        ARESET_N = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
